// File: rtl/mig_ui_responder_pkg.sv
// Shared definitions for the MIG 7-series app interface: command codes,
// default widths and the stall LFSR step used by the responder and the UI adapter.
package mig_ui_responder_pkg;
  localparam int DEF_APP_ADDR_WIDTH = 28;
  localparam int DEF_APP_CMD_WIDTH  = 3;
  localparam int DEF_APP_DATA_WIDTH = 128;
  localparam int DEF_APP_MASK_WIDTH = DEF_APP_DATA_WIDTH / 8;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/mig_ui_fifo.sv
// Four-entry FIFO with count-based full/empty; the caller gates push on !full
// and pop on !empty, so a push and pop in the same cycle while full is legal.
module mig_ui_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/mig_ui_responder.sv
// Behavioural MIG 7-series app-interface responder: calibration delay, LFSR
// back-pressure, in-order execution against an internal RAM, fixed read latency.
module mig_ui_responder
  import mig_ui_responder_pkg::*;
#(
  parameter int          APP_ADDR_WIDTH = DEF_APP_ADDR_WIDTH,
  parameter int          APP_CMD_WIDTH  = DEF_APP_CMD_WIDTH,
  parameter int          APP_DATA_WIDTH = DEF_APP_DATA_WIDTH,
  parameter int          APP_MASK_WIDTH = DEF_APP_MASK_WIDTH,
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          CALIB_CYCLES   = 64,
  parameter int          RD_LATENCY     = 4,
  parameter int          STALL_RATE     = 0,
  parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic [APP_ADDR_WIDTH-1:0] app_addr,
  input  logic [APP_CMD_WIDTH-1:0]  app_cmd,
  input  logic                      app_en,
  input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic                      app_wdf_wren,
  input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic                      app_rdy,
  output logic                      app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      o_init_calib_complete,
  output logic                      o_err
);
  localparam int          CMDQ_W    = APP_CMD_WIDTH + APP_ADDR_WIDTH;
  localparam int          WDQ_W     = APP_DATA_WIDTH + APP_MASK_WIDTH;
  localparam int          CNT_W     = $clog2(CALIB_CYCLES + 1);
  localparam logic [4:0]  STALL_THR = 5'(STALL_RATE);

  logic [CNT_W-1:0]          calib_cnt;
  logic [15:0]               lfsr;
  logic                      stall_c;
  logic                      stall_w;
  logic                      cmdq_full, cmdq_empty, wdq_full, wdq_empty;
  logic [CMDQ_W-1:0]         cmdq_head;
  logic [WDQ_W-1:0]          wdq_head;
  logic [APP_CMD_WIDTH-1:0]  hd_cmd;
  logic [APP_ADDR_WIDTH-1:0] hd_addr;
  logic [APP_DATA_WIDTH-1:0] wd_data;
  logic [APP_MASK_WIDTH-1:0] wd_mask;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic                      rd_go, wr_go, bad_go, cmd_pop;
  logic [APP_DATA_WIDTH-1:0] ram [2**MEM_ADDR_WIDTH];
  logic [APP_DATA_WIDTH-1:0] rd_word;
  logic [RD_LATENCY-1:0]     vld_p;
  logic                      out_vld_in;
  logic [APP_DATA_WIDTH-1:0] out_dat_in;
  logic                      unused_addr_bits;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      calib_cnt             <= '0;
      o_init_calib_complete <= 1'b0;
      lfsr                  <= STALL_SEED;
      o_err                 <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (!o_init_calib_complete) begin
        if (calib_cnt == CNT_W'(CALIB_CYCLES)) o_init_calib_complete <= 1'b1;
        else                                   calib_cnt <= calib_cnt + 1'b1;
      end
      if (bad_go) o_err <= 1'b1;
    end
  end

  assign stall_c     = ({1'b0, lfsr[3:0]} < STALL_THR);
  assign stall_w     = ({1'b0, lfsr[7:4]} < STALL_THR);
  assign app_rdy     = o_init_calib_complete & ~cmdq_full & ~stall_c;
  assign app_wdf_rdy = o_init_calib_complete & ~wdq_full & ~stall_w;

  mig_ui_fifo #(.WIDTH(CMDQ_W)) u_cmdq (
    .clk(clk), .rst(i_rst), .push(app_en & app_rdy), .push_data({app_cmd, app_addr}),
    .pop(cmd_pop), .head(cmdq_head), .full(cmdq_full), .empty(cmdq_empty)
  );

  mig_ui_fifo #(.WIDTH(WDQ_W)) u_wdq (
    .clk(clk), .rst(i_rst), .push(app_wdf_wren & app_wdf_rdy),
    .push_data({app_wdf_data, app_wdf_mask}),
    .pop(wr_go), .head(wdq_head), .full(wdq_full), .empty(wdq_empty)
  );

  assign {hd_cmd, hd_addr}  = cmdq_head;
  assign {wd_data, wd_mask} = wdq_head;
  assign idx                = hd_addr[MEM_ADDR_WIDTH+2:3];
  assign unused_addr_bits   = ^{hd_addr[APP_ADDR_WIDTH-1:MEM_ADDR_WIDTH+3], hd_addr[2:0]};

  // A write head with no data yet blocks everything behind it
  assign rd_go   = !cmdq_empty && (hd_cmd == APP_CMD_WIDTH'(CMD_READ));
  assign wr_go   = !cmdq_empty && (hd_cmd == APP_CMD_WIDTH'(CMD_WRITE)) && !wdq_empty;
  assign bad_go  = !cmdq_empty && (hd_cmd != APP_CMD_WIDTH'(CMD_READ))
                               && (hd_cmd != APP_CMD_WIDTH'(CMD_WRITE));
  assign cmd_pop = rd_go | wr_go | bad_go;

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++)
        if (!wd_mask[b]) ram[idx][b*8 +: 8] <= wd_data[b*8 +: 8];
    end
  end

  assign rd_word = ram[idx];

  // Read return: stage 0 loads at the execute edge, output stage is the last
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) vld_p <= '0;
    else       vld_p <= (vld_p << 1) | RD_LATENCY'(rd_go);
  end

  if (RD_LATENCY > 1) begin : g_dly
    logic [APP_DATA_WIDTH-1:0] dly_p [RD_LATENCY-1];
    always_ff @(posedge clk) begin
      if (rd_go) dly_p[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY - 1; i++)
        if (vld_p[i-1]) dly_p[i] <= dly_p[i-1];
    end
    assign out_vld_in = vld_p[RD_LATENCY-2];
    assign out_dat_in = dly_p[RD_LATENCY-2];
  end else begin : g_nodly
    assign out_vld_in = rd_go;
    assign out_dat_in = rd_word;
  end

  // Output data only moves with a valid beat, so it holds between beats
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)           app_rd_data <= '0;
    else if (out_vld_in) app_rd_data <= out_dat_in;
  end

  assign app_rd_data_valid = vld_p[RD_LATENCY-1];
endmodule

// File: tb/tb_mig_ui_responder.sv
// Scoreboard bench for mig_ui_responder: a memory-level model predicts every read
// beat; a negedge monitor pops and compares whenever app_rd_data_valid is seen.
module tb_mig_ui_responder;
  import mig_ui_responder_pkg::*;

  localparam int AW = 28, CW = 3, DW = 128, MW = 16;
  localparam int CALIB = 64, LAT = 4, NOPS = 200;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [AW-1:0] app_addr = '0;
  logic [CW-1:0] app_cmd = '0;
  logic          app_en = 1'b0;
  logic [DW-1:0] app_wdf_data = '0;
  logic          app_wdf_wren = 1'b0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_rdy, app_wdf_rdy, app_rd_data_valid, o_init_calib_complete, o_err;
  logic [DW-1:0] app_rd_data;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [1024];

  logic          op_wr   [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [DW-1:0] wd_list[$];
  logic [MW-1:0] wm_list[$];

  always #5 clk = ~clk;

  mig_ui_responder #(
    .APP_ADDR_WIDTH(AW), .APP_CMD_WIDTH(CW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
    .MEM_ADDR_WIDTH(10), .CALIB_CYCLES(CALIB), .RD_LATENCY(LAT),
    .STALL_RATE(8), .STALL_SEED(16'hACE1)
  ) dut (
    .clk(clk), .i_rst(i_rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_mask(app_wdf_mask),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .o_init_calib_complete(o_init_calib_complete),
    .o_err(o_err)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_beat: got data %h, expected no beat", app_rd_data);
      end else begin
        check("rd_data", app_rd_data, exp_q.pop_front());
      end
    end
  end

  function automatic int midx(input logic [AW-1:0] addr);
    return int'((addr >> 3) % 1024);
  endfunction

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                             input logic [MW-1:0] m);
    logic [DW-1:0] w;
    w = mdl[midx(addr)];
    for (int b = 0; b < MW; b++)
      if (!m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mdl[midx(addr)] = w;
  endtask

  task automatic send_cmd(input logic [CW-1:0] cmd, input logic [AW-1:0] addr);
    int n;
    n = 0;
    app_cmd = cmd; app_addr = addr; app_en = 1'b1;
    while (!app_rdy && n < 2000) begin @(negedge clk); n++; end
    if (!app_rdy) begin
      tests++; fails++;
      $display("FAIL cmd_handshake: app_rdy stayed 0, expected 1 within 2000 cycles");
    end
    @(negedge clk);
    app_en = 1'b0;
  endtask

  task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n;
    n = 0;
    app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1;
    while (!app_wdf_rdy && n < 2000) begin @(negedge clk); n++; end
    if (!app_wdf_rdy) begin
      tests++; fails++;
      $display("FAIL wdf_handshake: app_wdf_rdy stayed 0, expected 1 within 2000 cycles");
    end
    @(negedge clk);
    app_wdf_wren = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
    model_write(addr, d, m);
    send_wdf(d, m);
    send_cmd(CMD_WRITE, addr);
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    exp_q.push_back(mdl[midx(addr)]);
    send_cmd(CMD_READ, addr);
  endtask

  task automatic read_latency(input logic [AW-1:0] addr);
    do_read(addr);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      check($sformatf("rd_valid_edge%0d", k), DW'(app_rd_data_valid), DW'(k == LAT));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("outstanding_reads", DW'(exp_q.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [DW-1:0] beats [4];

    repeat (5) @(negedge clk);
    check("reset_flags", DW'({app_rdy, app_wdf_rdy, app_rd_data_valid,
                              o_init_calib_complete, o_err}), '0);
    check("reset_rd_data", app_rd_data, '0);
    i_rst = 1'b0;
    for (int k = 1; k <= CALIB; k++) begin
      @(posedge clk); #1;
      check("calib_pending", DW'({o_init_calib_complete, app_rdy, app_wdf_rdy}), '0);
    end
    @(posedge clk); #1;
    check("calib_done", DW'(o_init_calib_complete), DW'(1));
    @(negedge clk);

    // Full-word write, then a read on an idle queue to measure latency
    do_write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, '0);
    repeat (8) @(negedge clk);
    read_latency(28'h10);

    // Masked write: only the upper eight bytes land
    do_write(28'h28, '0, '0);
    do_write(28'h28, '1, 16'h00FF);
    do_read(28'h28);
    drain();

    // Write data ahead of its commands fills the data queue
    for (int i = 0; i < 4; i++) begin
      beats[i] = rand128();
      send_wdf(beats[i], '0);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("wdq_full_wdf_rdy", DW'(app_wdf_rdy), '0);
    end
    for (int i = 0; i < 4; i++) begin
      model_write(28'(i * 8), beats[i], '0);
      send_cmd(CMD_WRITE, 28'(i * 8));
    end
    for (int i = 0; i < 4; i++) do_read(28'(i * 8));
    drain();

    // A write head with no data blocks the reads queued behind it
    d = rand128();
    model_write(28'h20, d, '0);
    send_cmd(CMD_WRITE, 28'h20);
    for (int i = 0; i < 3; i++) do_read(28'h20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("cmdq_full_app_rdy", DW'(app_rdy), '0);
    end
    send_wdf(d, '0);
    drain();

    // Random traffic over preloaded, aliased addresses
    for (int i = 0; i < 16; i++) do_write(28'((32 + i) << 3), rand128(), '0);
    for (int i = 0; i < NOPS; i++) begin
      op_wr[i] = 1'($urandom_range(0, 1));
      a = 28'($urandom);
      a = (a & ~28'h1FFF) | (28'(32 + $urandom_range(0, 15)) << 3) | (a & 28'h7);
      op_addr[i] = a;
      if (op_wr[i]) begin
        wd_list.push_back(rand128());
        wm_list.push_back(16'($urandom));
      end
    end
    fork
      begin : cmd_proc
        int wi;
        wi = 0;
        for (int i = 0; i < NOPS; i++) begin
          if (op_wr[i]) begin
            model_write(op_addr[i], wd_list[wi], wm_list[wi]);
            wi++;
            send_cmd(CMD_WRITE, op_addr[i]);
          end else begin
            do_read(op_addr[i]);
          end
        end
      end
      begin : data_proc
        for (int j = 0; j < wd_list.size(); j++) send_wdf(wd_list[j], wm_list[j]);
      end
    join
    drain();

    // Unsupported command
    check("err_before", DW'(o_err), '0);
    send_cmd(3'b011, 28'h0);
    repeat (5) @(negedge clk);
    check("err_sticky", DW'(o_err), DW'(1));

    // Reset with three reads in flight
    d = rand128();
    model_write(28'h38, d, '0);
    send_cmd(CMD_WRITE, 28'h38);
    for (int i = 0; i < 3; i++) send_cmd(CMD_READ, 28'h38);
    send_wdf(d, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    check("midrun_reset_flags", DW'({app_rdy, app_wdf_rdy, app_rd_data_valid,
                                     o_init_calib_complete, o_err}), '0);
    check("midrun_reset_rd_data", app_rd_data, '0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (CALIB + 10) @(negedge clk);
    check("recalib_done", DW'(o_init_calib_complete), DW'(1));
    do_read(28'h10);
    do_read(28'h38);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
